// File: rtl/point_uart_reporter_if.sv
// Signal bundle between the multi-point finder / host side and the UART point
// reporter: frame sync, enable, the four point coordinates and the reporter status.
interface point_uart_reporter_if;
  logic        VGA_VS;
  logic        i_EN;
  logic [15:0] i_POINTS_H_0;
  logic [15:0] i_POINTS_H_1;
  logic [15:0] i_POINTS_H_2;
  logic [15:0] i_POINTS_H_3;
  logic [15:0] i_POINTS_V_0;
  logic [15:0] i_POINTS_V_1;
  logic [15:0] i_POINTS_V_2;
  logic [15:0] i_POINTS_V_3;
  logic        o_UART_TX;
  logic        o_BUSY;
  logic [7:0]  o_FRAME_CNT;
  logic [7:0]  o_DROP_CNT;

  modport master (
    output VGA_VS, i_EN,
    output i_POINTS_H_0, i_POINTS_H_1, i_POINTS_H_2, i_POINTS_H_3,
    output i_POINTS_V_0, i_POINTS_V_1, i_POINTS_V_2, i_POINTS_V_3,
    input  o_UART_TX, o_BUSY, o_FRAME_CNT, o_DROP_CNT
  );

  modport slave (
    input  VGA_VS, i_EN,
    input  i_POINTS_H_0, i_POINTS_H_1, i_POINTS_H_2, i_POINTS_H_3,
    input  i_POINTS_V_0, i_POINTS_V_1, i_POINTS_V_2, i_POINTS_V_3,
    output o_UART_TX, o_BUSY, o_FRAME_CNT, o_DROP_CNT
  );
endinterface

// File: rtl/point_uart_reporter.sv
// Snapshots the four tracked points at each frame end and sends them to the host as a
// 21-byte 8N1 UART packet; frame ends seen while a packet is in flight are dropped and counted.
module point_uart_reporter #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  point_uart_reporter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [4:0]  LAST_IDX  = 5'd20;

  state_t      state_q, state_d;
  logic        vs_q;
  logic        pending_q, pending_d;
  logic        tx_q, tx_d;
  logic [7:0]  frameCnt_q, frameCnt_d;
  logic [7:0]  dropCnt_q, dropCnt_d;
  logic [7:0]  frameByte_q, frameByte_d;
  logic [2:0]  ptCount_q, ptCount_d;
  logic [15:0] ptH_q [4];
  logic [15:0] ptH_d [4];
  logic [15:0] ptV_q [4];
  logic [15:0] ptV_d [4];
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [4:0]  idx_q, idx_d;

  logic        frameEnd, baudDone, lastStop, accept, drop;
  logic [2:0]  liveCount;
  logic [1:0]  wordSel;
  logic [15:0] selH, selV;
  logic [7:0]  curByte;

  assign liveCount = 3'(|{bus.i_POINTS_H_0, bus.i_POINTS_V_0})
                   + 3'(|{bus.i_POINTS_H_1, bus.i_POINTS_V_1})
                   + 3'(|{bus.i_POINTS_H_2, bus.i_POINTS_V_2})
                   + 3'(|{bus.i_POINTS_H_3, bus.i_POINTS_V_3});

  // Bytes 4..19 hold four bytes per point; idx[3:2]-1 maps 4..19 onto points 0..3.
  assign wordSel = idx_q[3:2] - 2'd1;
  assign selH    = ptH_q[wordSel];
  assign selV    = ptV_q[wordSel];

  always_comb begin
    curByte = sum_q;
    if (idx_q == 5'd0)         curByte = 8'hA5;
    else if (idx_q == 5'd1)    curByte = 8'h5A;
    else if (idx_q == 5'd2)    curByte = frameByte_q;
    else if (idx_q == 5'd3)    curByte = {5'd0, ptCount_q};
    else if (idx_q < LAST_IDX) begin
      case (idx_q[1:0])
        2'd0:    curByte = selH[15:8];
        2'd1:    curByte = selH[7:0];
        2'd2:    curByte = selV[15:8];
        default: curByte = selV[7:0];
      endcase
    end
  end

  // The edge that ends the final stop bit also frees the transmitter, so a frame end there is taken.
  assign frameEnd = vs_q & ~bus.VGA_VS;
  assign baudDone = (baud_q == BAUD_LAST);
  assign lastStop = (state_q == STOP) && baudDone && (idx_q == LAST_IDX);
  assign accept   = frameEnd && bus.i_EN && !pending_q && ((state_q == IDLE) || lastStop);
  assign drop     = frameEnd && bus.i_EN && !accept;

  always_comb begin
    state_d     = state_q;
    pending_d   = accept;
    tx_d        = tx_q;
    frameByte_d = frameByte_q;
    ptCount_d   = ptCount_q;
    ptH_d       = ptH_q;
    ptV_d       = ptV_q;
    sum_d       = sum_q;
    shift_d     = shift_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    idx_d       = idx_q;
    frameCnt_d  = frameCnt_q + {7'd0, pending_q} + {7'd0, drop};
    dropCnt_d   = (drop && (dropCnt_q != 8'hFF)) ? dropCnt_q + 8'd1 : dropCnt_q;

    if (pending_q) begin
      ptH_d       = '{bus.i_POINTS_H_0, bus.i_POINTS_H_1, bus.i_POINTS_H_2, bus.i_POINTS_H_3};
      ptV_d       = '{bus.i_POINTS_V_0, bus.i_POINTS_V_1, bus.i_POINTS_V_2, bus.i_POINTS_V_3};
      frameByte_d = frameCnt_q;
      ptCount_d   = liveCount;
      sum_d       = 8'd0;
      idx_d       = 5'd0;
      state_d     = LOAD;
    end

    // The line is registered from the current state, so it trails the FSM by one cycle.
    case (state_q)
      IDLE: tx_d = 1'b1;
      LOAD: begin
        shift_d = curByte;
        if ((idx_q >= 5'd2) && (idx_q < LAST_IDX)) sum_d = sum_q + curByte;
        baud_d  = 16'd0;
        bit_d   = 3'd0;
        state_d = START;
      end
      START: begin
        tx_d = 1'b0;
        if (baudDone) begin
          baud_d  = 16'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baudDone) begin
          baud_d  = 16'd0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baudDone) begin
          baud_d = 16'd0;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = LOAD;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      vs_q        <= 1'b0;
      pending_q   <= 1'b0;
      tx_q        <= 1'b1;
      frameCnt_q  <= 8'd0;
      dropCnt_q   <= 8'd0;
      frameByte_q <= 8'd0;
      ptCount_q   <= 3'd0;
      sum_q       <= 8'd0;
      shift_q     <= 8'd0;
      baud_q      <= 16'd0;
      bit_q       <= 3'd0;
      idx_q       <= 5'd0;
      for (int k = 0; k < 4; k++) begin
        ptH_q[k] <= 16'd0;
        ptV_q[k] <= 16'd0;
      end
    end else begin
      state_q     <= state_d;
      vs_q        <= bus.VGA_VS;
      pending_q   <= pending_d;
      tx_q        <= tx_d;
      frameCnt_q  <= frameCnt_d;
      dropCnt_q   <= dropCnt_d;
      frameByte_q <= frameByte_d;
      ptCount_q   <= ptCount_d;
      sum_q       <= sum_d;
      shift_q     <= shift_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      idx_q       <= idx_d;
      ptH_q       <= ptH_d;
      ptV_q       <= ptV_d;
    end
  end

  assign bus.o_UART_TX   = tx_q;
  assign bus.o_BUSY      = pending_q | (state_q != IDLE);
  assign bus.o_FRAME_CNT = frameCnt_q;
  assign bus.o_DROP_CNT  = dropCnt_q;

endmodule

// File: tb/tb_point_uart_reporter.sv
// Randomised self-checking bench: a UART receiver decodes the line and a packet-level
// model of the reporter supplies the expected bytes and counter values.
module tb_point_uart_reporter;

  localparam int CPB = 4;
  localparam int PKT_CYCLES = 21 * (10 * CPB + 1);

  logic CLK;
  logic RESET_N;

  point_uart_reporter_if bus ();

  point_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] ptH [4];
  logic [15:0] ptV [4];
  logic [7:0]  mFrame;
  logic [7:0]  mDrop;
  logic [7:0]  expQ [$];

  logic [7:0]  rxQ [$];
  int          rxBase = 0;
  bit          rxActive = 1'b0;
  int          rxCnt = 0;
  int          rxBit = 0;
  logic [7:0]  rxByte = 8'd0;
  int          rxFrameErr = 0;

  // Clock generation
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Absolute time limit so a stuck design cannot hang the run
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // UART receiver: samples the line mid-bit and pushes every complete 8N1 byte
  always begin
    @(posedge CLK);
    #1;
    if (!RESET_N) begin
      rxActive = 1'b0;
    end else if (!rxActive) begin
      if (bus.o_UART_TX === 1'b0) begin
        rxActive = 1'b1;
        rxCnt = 0;
      end
    end else begin
      rxCnt++;
      if ((rxCnt % CPB) == (CPB / 2)) begin
        rxBit = rxCnt / CPB;
        if (rxBit == 0) begin
          if (bus.o_UART_TX !== 1'b0) rxFrameErr++;
        end else if (rxBit <= 8) begin
          rxByte[rxBit-1] = bus.o_UART_TX;
        end else begin
          if (bus.o_UART_TX !== 1'b1) rxFrameErr++;
          rxQ.push_back(rxByte);
          rxActive = 1'b0;
        end
      end
    end
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drivePoints();
    bus.i_POINTS_H_0 = ptH[0]; bus.i_POINTS_V_0 = ptV[0];
    bus.i_POINTS_H_1 = ptH[1]; bus.i_POINTS_V_1 = ptV[1];
    bus.i_POINTS_H_2 = ptH[2]; bus.i_POINTS_V_2 = ptV[2];
    bus.i_POINTS_H_3 = ptH[3]; bus.i_POINTS_V_3 = ptV[3];
  endtask

  // Garbage on the point bus after the snapshot must not reach the packet
  task automatic scramblePoints();
    bus.i_POINTS_H_0 = 16'($urandom); bus.i_POINTS_V_0 = 16'($urandom);
    bus.i_POINTS_H_1 = 16'($urandom); bus.i_POINTS_V_1 = 16'($urandom);
    bus.i_POINTS_H_2 = 16'($urandom); bus.i_POINTS_V_2 = 16'($urandom);
    bus.i_POINTS_H_3 = 16'($urandom); bus.i_POINTS_V_3 = 16'($urandom);
  endtask

  task automatic randomPoints();
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        ptH[k] = 16'd0;
        ptV[k] = 16'd0;
      end else begin
        ptH[k] = 16'($urandom);
        ptV[k] = 16'($urandom);
      end
    end
    drivePoints();
  endtask

  // VS low for one cycle; the frame end is detected on the rising edge in between
  task automatic applyStimulus();
    @(negedge CLK) bus.VGA_VS = 1'b0;
    @(negedge CLK) bus.VGA_VS = 1'b1;
  endtask

  // Reference packet straight from the packet layout rules
  task automatic queuePacket(input logic [7:0] fc);
    logic [7:0] pkt [21];
    int live;
    logic [7:0] sum;
    live = 0;
    for (int k = 0; k < 4; k++) if (ptH[k] != 16'd0 || ptV[k] != 16'd0) live++;
    pkt[0] = 8'hA5;
    pkt[1] = 8'h5A;
    pkt[2] = fc;
    pkt[3] = 8'(live);
    for (int k = 0; k < 4; k++) begin
      pkt[4 + 4*k] = ptH[k][15:8];
      pkt[5 + 4*k] = ptH[k][7:0];
      pkt[6 + 4*k] = ptV[k][15:8];
      pkt[7 + 4*k] = ptV[k][7:0];
    end
    sum = 8'd0;
    for (int i = 2; i <= 19; i++) sum = sum + pkt[i];
    pkt[20] = sum;
    for (int i = 0; i < 21; i++) expQ.push_back(pkt[i]);
  endtask

  // Counter and packet model for one frame end; inFlight is known from the schedule
  task automatic modelFrame(input bit en, input bit inFlight);
    if (en) begin
      if (inFlight) begin
        if (mDrop != 8'hFF) mDrop = mDrop + 8'd1;
      end else begin
        queuePacket(mFrame);
      end
      mFrame = mFrame + 8'd1;
    end
  endtask

  task automatic waitIdle(input string tag);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(posedge CLK);
      #1;
      if (bus.o_BUSY === 1'b0) done = 1'b1;
    end
    checkOutput({tag, " idle"}, 32'(done), 32'd1);
    repeat (2 * CPB) @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] rxAt(input int i);
    if (rxBase + i < rxQ.size()) return 32'(rxQ[rxBase + i]);
    return 32'hDEAD;
  endfunction

  task automatic compareRx(input string tag);
    int got;
    int n;
    got = rxQ.size() - rxBase;
    checkOutput({tag, " bytes"}, 32'(got), 32'(expQ.size()));
    n = (got < expQ.size()) ? got : expQ.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s byte%0d", tag, i), 32'(rxQ[rxBase + i]), 32'(expQ[i]));
    rxBase = rxQ.size();
    expQ.delete();
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, " frame_cnt"}, 32'(bus.o_FRAME_CNT), 32'(mFrame));
    checkOutput({tag, " drop_cnt"}, 32'(bus.o_DROP_CNT), 32'(mDrop));
  endtask

  initial begin
    int lat;
    int busyCnt;
    bit done;
    logic [7:0] fcT2;
    bit en;
    bit dropIt;
    bit dropEn;

    RESET_N = 1'b0;
    bus.VGA_VS = 1'b1;
    bus.i_EN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ptH[k] = 16'd0;
      ptV[k] = 16'd0;
    end
    drivePoints();
    mFrame = 8'd0;
    mDrop = 8'd0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset tx", 32'(bus.o_UART_TX), 32'd1);
    checkOutput("reset busy", 32'(bus.o_BUSY), 32'd0);
    checkCounters("reset");
    @(negedge CLK) RESET_N = 1'b1;

    // T1: directed packet, latency and length
    ptH = '{16'd100, 16'd300, 16'd0, 16'd0};
    ptV = '{16'd50, 16'd200, 16'd0, 16'd0};
    drivePoints();
    @(negedge CLK) bus.VGA_VS = 1'b0;
    @(posedge CLK);
    #1;
    checkOutput("T1 pending busy", 32'(bus.o_BUSY), 32'd1);
    modelFrame(1'b1, 1'b0);
    bus.VGA_VS = 1'b1;
    lat = 0;
    busyCnt = 1;
    done = 1'b0;
    for (int n = 1; n < 5000 && !done; n++) begin
      @(posedge CLK);
      #1;
      if (bus.o_UART_TX === 1'b0 && lat == 0) lat = n;
      if (bus.o_BUSY === 1'b1) busyCnt++;
      else done = 1'b1;
    end
    checkOutput("T1 busy ends", 32'(done), 32'd1);
    checkOutput("T1 start latency", 32'(lat), 32'd3);
    checkOutput("T1 busy cycles", 32'(busyCnt), 32'(1 + PKT_CYCLES));
    repeat (2 * CPB) @(posedge CLK);
    #1;
    checkCounters("T1");
    checkOutput("T1 count byte", rxAt(3), 32'h02);
    checkOutput("T1 checksum", rxAt(20), 32'h8D);
    compareRx("T1");

    // T2: four nonzero points
    ptH = '{16'd1, 16'd2, 16'd3, 16'd4};
    ptV = '{16'd1, 16'd2, 16'd3, 16'd4};
    drivePoints();
    fcT2 = mFrame;
    applyStimulus();
    modelFrame(1'b1, 1'b0);
    @(negedge CLK) scramblePoints();
    waitIdle("T2");
    checkOutput("T2 count byte", rxAt(3), 32'h04);
    checkOutput("T2 checksum", rxAt(20), 32'(8'(fcT2 + 8'd24)));
    compareRx("T2");
    checkCounters("T2");

    // T5: reset in the middle of the first byte's data bits
    randomPoints();
    applyStimulus();
    modelFrame(1'b1, 1'b0);
    repeat (20) @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    checkOutput("T5 async tx", 32'(bus.o_UART_TX), 32'd1);
    checkOutput("T5 async busy", 32'(bus.o_BUSY), 32'd0);
    checkOutput("T5 async frame_cnt", 32'(bus.o_FRAME_CNT), 32'd0);
    checkOutput("T5 async drop_cnt", 32'(bus.o_DROP_CNT), 32'd0);
    @(negedge CLK) RESET_N = 1'b1;
    mFrame = 8'd0;
    mDrop = 8'd0;
    expQ.delete();
    repeat (2) @(posedge CLK);
    #1;
    rxBase = rxQ.size();

    // T3: packet after reset, with a second frame end ~100 cycles in
    randomPoints();
    applyStimulus();
    modelFrame(1'b1, 1'b0);
    @(negedge CLK) scramblePoints();
    repeat (98) @(negedge CLK);
    applyStimulus();
    modelFrame(1'b1, 1'b1);
    waitIdle("T3");
    checkOutput("T3 frame byte", rxAt(2), 32'h00);
    checkOutput("T3 drop_cnt", 32'(bus.o_DROP_CNT), 32'd1);
    checkOutput("T3 frame_cnt", 32'(bus.o_FRAME_CNT), 32'd2);
    compareRx("T3");
    randomPoints();
    applyStimulus();
    modelFrame(1'b1, 1'b0);
    waitIdle("T3b");
    checkOutput("T3b frame byte", rxAt(2), 32'h02);
    compareRx("T3b");
    checkCounters("T3b");

    // T4: disabled frame end, then enabled
    bus.i_EN = 1'b0;
    applyStimulus();
    modelFrame(1'b0, 1'b0);
    repeat (30) @(posedge CLK);
    #1;
    checkOutput("T4 busy", 32'(bus.o_BUSY), 32'd0);
    compareRx("T4 disabled");
    checkCounters("T4 disabled");
    bus.i_EN = 1'b1;
    randomPoints();
    applyStimulus();
    modelFrame(1'b1, 1'b0);
    waitIdle("T4");
    compareRx("T4 enabled");
    checkCounters("T4 enabled");

    // T6: frame end on the edge that ends the last stop bit is accepted
    randomPoints();
    applyStimulus();
    modelFrame(1'b1, 1'b0);
    @(negedge CLK) randomPoints();
    repeat (859) @(negedge CLK);
    applyStimulus();
    modelFrame(1'b1, 1'b0);
    waitIdle("T6");
    compareRx("T6");
    checkCounters("T6");

    // T7: randomised frames, enables and in-flight drops
    for (int it = 0; it < 6; it++) begin
      randomPoints();
      en = ($urandom_range(0, 3) != 0);
      dropIt = en && ($urandom_range(0, 1) == 1);
      bus.i_EN = en;
      applyStimulus();
      modelFrame(en, 1'b0);
      @(negedge CLK) scramblePoints();
      if (dropIt) begin
        repeat ($urandom_range(1, 700)) @(negedge CLK);
        dropEn = ($urandom_range(0, 3) != 0);
        bus.i_EN = dropEn;
        applyStimulus();
        modelFrame(dropEn, 1'b1);
      end
      waitIdle($sformatf("T7.%0d", it));
      compareRx($sformatf("T7.%0d", it));
      checkCounters($sformatf("T7.%0d", it));
    end
    bus.i_EN = 1'b1;

    // T8: 300 frame ends during one packet saturate the drop counter
    randomPoints();
    applyStimulus();
    modelFrame(1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      applyStimulus();
      modelFrame(1'b1, 1'b1);
    end
    waitIdle("T8");
    checkOutput("T8 drop saturated", 32'(bus.o_DROP_CNT), 32'd255);
    compareRx("T8");
    checkCounters("T8");

    checkOutput("uart framing errors", 32'(rxFrameErr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/point_uart_reporter.md
# point_uart_reporter

Downstream consumer of the multi-point finder. At every frame end it snapshots the four point coordinates (H/V, 16 bit each) and serialises them to the host as a fixed 21-byte UART packet (8N1, LSB first) for offline tracking and logging. A frame that ends while a packet is still in flight is dropped and counted, never queued.

## Interface
Parameters:
- CLKS_PER_BIT, default 217: clock cycles per UART bit (25 MHz / 115200); legal range 2..65535.

Ports:
- CLK  in  1  pixel/system clock
- RESET_N  in  1  asynchronous, active-low reset
- VGA_VS  in  1  vertical sync; falling edge marks frame end
- i_EN  in  1  1 = report frames; 0 = ignore frame ends (packet in flight still completes)
- i_POINTS_H_0..3, i_POINTS_V_0..3  in  16 each  point coordinates from the multi-point finder
- o_UART_TX  out  1  serial line, idle high
- o_BUSY  out  1  packet in flight
- o_FRAME_CNT  out  8  frames detected while i_EN=1, mod 256
- o_DROP_CNT  out  8  frames dropped because o_BUSY=1, saturates at 255

## Operation
- Edge detect: register VGA_VS into rVS. A frame end is detected on a clock edge where rVS=1 and VGA_VS=0.
- Snapshot timing: the upstream finder updates its point outputs on that same edge. The snapshot is therefore taken on the next rising edge.
- On a detected frame end with i_EN=1:
  - If o_BUSY=0: set pending. On the next edge, capture the 8 point words, the current o_FRAME_CNT, and the point count. Then increment o_FRAME_CNT and enter LOAD.
  - If o_BUSY=1 (including the pending cycle): increment o_FRAME_CNT, increment o_DROP_CNT (saturating), and leave the current packet untouched.
- Point count: the number of indices k in 0..3 for which H_k != 0 or V_k != 0. Range 0..4.
- Packet byte order (index 0..20):
  - 0xA5, 0x5A (header)
  - frame count
  - point count
  - for k = 0..3: H_k[15:8], H_k[7:0], V_k[15:8], V_k[7:0]
  - checksum = sum of bytes 2..19, mod 256
- The checksum accumulates as bytes are loaded. Bytes are emitted back-to-back with no inter-byte gap.
- FSM states:
  - IDLE: wait for a snapshot.
  - LOAD: select byte[idx] into the shift register; 1 cycle, line held at its current level.
  - START: TX=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: TX=1 for CLKS_PER_BIT cycles. Then LOAD with idx+1 if idx<20, otherwise IDLE.
- o_BUSY = 1 from the snapshot edge through the last STOP cycle. It also reads 1 during the pending cycle.
- Width rules: bit counter 3 bit, byte index 5 bit, baud counter 16 bit, checksum 8 bit (wraps).

## Timing
- Reset (asynchronous, immediate): o_UART_TX=1, o_BUSY=0, o_FRAME_CNT=0, o_DROP_CNT=0, state IDLE, pending=0. Reset mid-packet aborts with the line high; no partial byte resumes.
- Latency:
  - Frame-end detection edge to TX start-bit falling edge: 3 cycles (pending, snapshot, LOAD).
  - Packet length: 21×(10×CLKS_PER_BIT + 1) cycles, including 1 LOAD cycle per byte.
- o_BUSY falls on the edge after the last stop-bit cycle. A frame end detected on that same edge is accepted, not dropped.
- i_EN is sampled only at frame-end detection.
- Input points are not required to be stable outside the snapshot cycle.
- VGA_VS glitches shorter than one cycle are not filtered; VS is treated as synchronous to CLK.

## Test plan
- Single frame, CLKS_PER_BIT=4, points (100,50),(300,200),(0,0),(0,0), first frame after reset -> 21 bytes A5 5A 00 02 00 64 00 32 01 2C 00 C8 00…00 8D; start bit 3 cycles after detection; packet lasts 861 cycles; o_FRAME_CNT=1.
- Four nonzero points (1,1),(2,2),(3,3),(4,4) -> count byte 04; checksum = (frame cnt+4+20) mod 256; bit-level 8N1 decode matches the expected bytes.
- Second VS falling edge 100 cycles into the packet -> packet unchanged, o_DROP_CNT=1, o_FRAME_CNT=2; the next accepted packet carries frame byte 02.
- i_EN=0 at a frame end -> no packet, o_FRAME_CNT unchanged; i_EN=1 at the next frame end -> normal packet.
- RESET_N asserted mid-DATA -> o_UART_TX=1 and o_BUSY=0 asynchronously, counters cleared; after release, the next frame produces a complete packet with frame byte 00.
- 300 frame ends issued during continuous busy -> o_DROP_CNT saturates at 255 while o_FRAME_CNT wraps mod 256.
